// File: rtl/i2c_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_arbiter
//
// Shares one I2C register-access driver between two requesters. A request is
// granted from IDLE, its read/write select, word address and write byte are
// latched toward the driver, the driver is started with a one-cycle exec pulse,
// and the arbiter waits for the driver's done pulse. The granted requester then
// gets a one-cycle done pulse, with the read byte on data_r. When both
// requesters ask at once, the one not served last wins. After reset,
// requester 0 wins.
//
// Optional build macro:
//   I2C_ARB_TIMEOUT_EN - adds a WAIT-state watchdog. After TIMEOUT_CYC cycles
//                        in WAIT without i2c_done, the transaction completes
//                        with err set and data_r = 8'hFF. Without the macro,
//                        err is tied to zero and WAIT never times out.
//
// Ports
//   clk         in   1   single clock, rising edge
//   rst         in   1   synchronous active-high reset
//   req         in   2   per-requester request level (bit n = requester n)
//   rh_wl       in   2   per-requester read(1)/write(0)
//   addr        in  32   per-requester word address, [16n+15:16n]
//   data_w      in  16   per-requester write byte, [8n+7:8n]
//   done        out  2   one-cycle completion pulse to the granted requester
//   err         out  2   abort flag, qualified by done
//   data_r      out  8   last read byte (held across writes)
//   i2c_exec    out  1   one-cycle start pulse to the driver
//   i2c_rh_wl   out  1   latched read/write select
//   i2c_addr    out 16   latched word address
//   i2c_data_w  out  8   latched write byte
//   i2c_data_r  in   8   read byte from the driver, valid with i2c_done
//   i2c_done    in   1   driver completion pulse
// -----------------------------------------------------------------------------
module i2c_arbiter #(
   parameter logic [19:0] TIMEOUT_CYC = 20'd500_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  rh_wl,
   input  logic [31:0] addr,
   input  logic [15:0] data_w,
   output logic [1:0]  done,
   output logic [1:0]  err,
   output logic [7:0]  data_r,
   output logic        i2c_exec,
   output logic        i2c_rh_wl,
   output logic [15:0] i2c_addr,
   output logic [7:0]  i2c_data_w,
   input  logic [7:0]  i2c_data_r,
   input  logic        i2c_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      state_reg, state_next;
   logic        grant_reg, grant_next;
   logic        last_reg;
   logic        rh_wl_reg;
   logic [15:0] addr_reg;
   logic [7:0]  data_w_reg;
   logic [7:0]  data_r_reg;
   logic        timeout_hit;

   // Per-requester views of the packed request buses.
   logic [15:0] addr_arr   [2];
   logic [7:0]  data_w_arr [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req_view
         assign addr_arr[gi]   = addr[16*gi +: 16];
         assign data_w_arr[gi] = data_w[8*gi +: 8];
      end
   endgenerate

`ifdef I2C_ARB_TIMEOUT_EN
   // Counts WAIT cycles. Cleared in EXEC, so it starts at zero on WAIT entry.
   logic [19:0] wait_cnt_reg;
   logic        err_reg;

   assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == TIMEOUT_CYC - 20'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_reg <= '0;
      end else if (state_reg == EXEC) begin
         wait_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
         wait_cnt_reg <= wait_cnt_reg + 20'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (state_reg == EXEC) begin
         err_reg <= 1'b0;
      end else if (state_reg == WAIT && !i2c_done && timeout_hit) begin
         // A driver done in the same cycle as the timeout wins.
         err_reg <= 1'b1;
      end
   end

   assign err = done & {2{err_reg}};
`else
   // The timeout value has no hardware in this build.
   if (TIMEOUT_CYC == 20'd0) begin : g_no_timeout
   end

   assign timeout_hit = 1'b0;
   assign err         = 2'b00;
`endif

   // Next-state and grant selection.
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               // Both asking: the one not served last. One asking: that one.
               grant_next = (req == 2'b11) ? ~last_reg : req[1];
               state_next = EXEC;
            end
         end
         EXEC: state_next = WAIT;
         WAIT: begin
            if (i2c_done || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         grant_reg  <= 1'b0;
         last_reg   <= 1'b1;
         rh_wl_reg  <= 1'b0;
         addr_reg   <= '0;
         data_w_reg <= '0;
         data_r_reg <= '0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;

         if (state_reg == IDLE && req != 2'b00) begin
            rh_wl_reg  <= rh_wl[grant_next];
            addr_reg   <= addr_arr[grant_next];
            data_w_reg <= data_w_arr[grant_next];
         end

         if (state_reg == WAIT) begin
            if (i2c_done) begin
               // Writes leave the previous read byte in place.
               if (rh_wl_reg) begin
                  data_r_reg <= i2c_data_r;
               end
            end else if (timeout_hit) begin
               data_r_reg <= 8'hFF;
            end
         end

         if (state_reg == RESP) begin
            last_reg <= grant_reg;
         end
      end
   end

   assign done       = (state_reg == RESP) ? (grant_reg ? 2'b10 : 2'b01) : 2'b00;
   assign data_r     = data_r_reg;
   assign i2c_exec   = (state_reg == EXEC);
   assign i2c_rh_wl  = rh_wl_reg;
   assign i2c_addr   = addr_reg;
   assign i2c_data_w = data_w_reg;

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 20'd500_000: WAIT-state cycles before a transaction is aborted (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port req  input  2  per-requester transaction request, level, bit n = requester n.
REQ-005 The block SHALL have port rh_wl  input  2  per-requester read(1)/write(0) select.
REQ-006 The block SHALL have port addr  input  32  per-requester word address, requester n on bits [16n+15:16n].
REQ-007 The block SHALL have port data_w  input  16  per-requester write byte, requester n on bits [8n+7:8n].
REQ-008 The block SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port err  output  2  abort flag, valid only in the cycle its done bit pulses.
REQ-010 The block SHALL have port data_r  output  8  read byte, valid while any done bit is high.
REQ-011 The block SHALL have port i2c_exec  output  1  one-cycle start pulse to the I2C driver.
REQ-012 The block SHALL have port i2c_rh_wl  output  1  latched read/write select to the driver.
REQ-013 The block SHALL have port i2c_addr  output  16  latched word address to the driver.
REQ-014 The block SHALL have port i2c_data_w  output  8  latched write byte to the driver.
REQ-015 The block SHALL have port i2c_data_r  input  8  read byte from the driver, valid with i2c_done.
REQ-016 The block SHALL have port i2c_done  input  1  driver completion pulse.

Function
REQ-017 The block SHALL implement FSM states IDLE, EXEC, WAIT, RESP.
REQ-018 In IDLE, if req is non-zero, the block SHALL select grant g, latch rh_wl[g], addr[g] and data_w[g] onto i2c_rh_wl, i2c_addr and i2c_data_w, and enter EXEC.
REQ-019 On simultaneous requests, the requester other than the last-served one SHALL win; after reset requester 0 wins.
REQ-020 EXEC SHALL assert i2c_exec for exactly one cycle and enter WAIT. If req is sampled in IDLE at edge N, i2c_exec SHALL be high in cycle N+1.
REQ-021 In WAIT, on i2c_done the block SHALL capture i2c_data_r into data_r and enter RESP.
REQ-022 RESP SHALL pulse done[g] for one cycle, update last-served to g, and return to IDLE. done SHALL therefore pulse exactly one cycle after i2c_done.
REQ-023 The latched driver outputs SHALL remain stable from EXEC until the next grant.
REQ-024 A req bit dropped before grant SHALL be ignored. A req bit dropped after grant SHALL NOT abort the transaction; done still pulses.
REQ-025 i2c_done received in IDLE, EXEC or RESP SHALL be ignored.
REQ-026 A requester still holding req in the cycle after its done SHALL start a new transaction, subject to REQ-019.
REQ-027 For a write, data_r SHALL hold its previous value.
REQ-028 At most one done bit SHALL ever be high, and at most one transaction SHALL be outstanding at the driver.

Reset
REQ-029 rst, sampled high at a clock edge, SHALL force IDLE, last-served = 1, and i2c_exec, done, err = 0; data_r, i2c_addr, i2c_data_w = 0; i2c_rh_wl = 0.
REQ-030 Reset during WAIT SHALL discard the transaction without any done pulse; a later i2c_done SHALL be ignored per REQ-025.

Configuration
REQ-031 With macro I2C_ARB_TIMEOUT_EN defined, a counter cleared on entry to WAIT SHALL count WAIT cycles. When it reaches TIMEOUT_CYC without i2c_done, the block SHALL enter RESP with err[g]=1 and data_r=8'hFF. i2c_done in the same cycle as the timeout SHALL take precedence, giving a normal completion.
REQ-032 Without I2C_ARB_TIMEOUT_EN, no counter SHALL be built, err SHALL be constant 0, and WAIT SHALL wait indefinitely.

Verification
REQ-033 Scenario: req=2'b01, write, addr0=16'h0010, data_w0=8'hA5; driver done after 40 cycles -> i2c_exec one cycle after req sampled, i2c_addr=16'h0010, i2c_data_w=8'hA5, done=2'b01 one cycle after i2c_done.
REQ-034 Scenario: req=2'b11 held continuously -> grants alternate 0,1,0,1 across four transactions.
REQ-035 Scenario: read on requester 1, i2c_data_r=8'h3C with i2c_done -> data_r=8'h3C while done=2'b10.
REQ-036 Scenario: rst asserted mid-WAIT, then i2c_done pulses -> no done pulse; outputs at reset values.
REQ-037 Scenario (macro defined, TIMEOUT_CYC=100): no i2c_done -> done[g]=1, err[g]=1, data_r=8'hFF, 100 cycles after WAIT entry plus one cycle for RESP.
REQ-038 Scenario: i2c_done pulse while in IDLE -> no done pulse, state unchanged.
